// File: rtl/life_sequencer.sv
// Generation sequencer for the 8x8 Game-of-Life datapath: owns the grid register,
// commits evolved generations under load/run/step/rate control and halts on end conditions.
module life_sequencer #(
  parameter int unsigned GRID_W = 64,
  parameter int unsigned DIV_W  = 24,
  parameter int unsigned GEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_W-1:0] seed,
  input  logic              load,
  input  logic              run,
  input  logic              step,
  input  logic [DIV_W-1:0]  rate,
  input  logic [GEN_W-1:0]  gen_limit,
  input  logic [GRID_W-1:0] grid_next,
  output logic [GRID_W-1:0] grid,
  output logic [GEN_W-1:0]  gen_count,
  output logic [1:0]        state,
  output logic              stable,
  output logic              extinct,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] divider;
  logic             step_q;

  logic             step_pulse;
  logic             same_c;
  logic             halt_c;
  logic             commit_c;
  logic [GEN_W-1:0] gen_inc;

  // Commit qualification and halt conditions for the current cycle
  always_comb begin
    step_pulse = step & ~step_q;
    gen_inc    = gen_count + GEN_W'(1);
    same_c     = (grid_next == grid);
    halt_c     = same_c || (grid_next == '0) ||
                 ((gen_limit != '0) && (gen_inc == gen_limit));
    commit_c   = !load &&
                 (((state_q == PAUSE) && !run && step_pulse) ||
                  ((state_q == RUN) && run && (divider == rate)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grid      <= '0;
      gen_count <= '0;
      divider   <= '0;
      step_q    <= 1'b0;
      stable    <= 1'b0;
      state_q   <= IDLE;
    end else begin
      step_q <= step;
      if (load) begin
        grid      <= seed;
        gen_count <= '0;
        divider   <= '0;
        stable    <= 1'b0;
        state_q   <= PAUSE;
      end else begin
        if (commit_c) begin
          grid      <= grid_next;
          gen_count <= (gen_count == '1) ? gen_count : gen_inc;
          stable    <= same_c;
        end
        case (state_q)
          PAUSE: begin
            if (run) begin
              state_q <= RUN;
              divider <= '0;
            end else if (commit_c && halt_c) begin
              state_q <= HALT;
            end
          end
          RUN: begin
            if (!run) begin
              state_q <= PAUSE;
              divider <= '0;
            end else if (commit_c) begin
              divider <= '0;
              if (halt_c) state_q <= HALT;
            end else begin
              // A rate lowered below divider wraps through all-ones back to zero
              divider <= divider + DIV_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state   = state_q;
  assign extinct = (grid == '0);
  assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_life_sequencer.sv
// Table-driven bench for life_sequencer; a golden Life evolve function stands in for the datapath.
module tb_life_sequencer;

  localparam logic [63:0] BLNK = 64'h0000_0000_0000_0E00;
  localparam logic [63:0] VERT = 64'h0000_0000_0004_0404;
  localparam logic [63:0] BLK  = 64'h0000_0000_0000_0303;
  localparam logic [1:0]  S_ID = 2'b00;
  localparam logic [1:0]  S_RN = 2'b01;
  localparam logic [1:0]  S_PS = 2'b10;
  localparam logic [1:0]  S_HL = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] seed;
  logic        load, run, step;
  logic [23:0] rate;
  logic [15:0] gen_limit;
  logic [63:0] grid_next;
  logic [63:0] grid;
  logic [15:0] gen_count;
  logic [1:0]  state;
  logic        stable, extinct, halted;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ld, rn, st;
    logic [63:0] sd;
    logic [23:0] rt;
    logic [15:0] lim;
    int          rep;
    logic [63:0] e_grid;
    logic [15:0] e_gen;
    logic [1:0]  e_st;
    logic        e_stb;
  } vec_t;

  typedef struct {
    logic [63:0] e_grid;
    logic [15:0] e_gen;
    logic [1:0]  e_st;
    logic        e_stb;
    int          idx;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  // Non-wrapping 8x8 Life rule: birth on 3 neighbours, survival on 2 or 3
  function automatic logic [63:0] life_f(input logic [63:0] g);
    logic [63:0] n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
              if (g[rr*8+cc]) cnt++;
          end
        end
        n[r*8+c] = (cnt == 3) || (g[r*8+c] && cnt == 2);
      end
    end
    return n;
  endfunction

  assign grid_next = life_f(grid);

  life_sequencer dut (
    .clk(clk), .reset(reset), .seed(seed), .load(load), .run(run), .step(step),
    .rate(rate), .gen_limit(gen_limit), .grid_next(grid_next), .grid(grid),
    .gen_count(gen_count), .state(state), .stable(stable), .extinct(extinct),
    .halted(halted)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic rn, input logic st, input logic [63:0] sd,
                     input logic [23:0] rt, input logic [15:0] lim, input int rep,
                     input logic [63:0] eg, input logic [15:0] en, input logic [1:0] es,
                     input logic eb);
    vec_t v;
    v.ld = ld; v.rn = rn; v.st = st; v.sd = sd; v.rt = rt; v.lim = lim; v.rep = rep;
    v.e_grid = eg; v.e_gen = en; v.e_st = es; v.e_stb = eb;
    vt.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check($sformatf("%s grid", tag), grid, e.e_grid);
    check($sformatf("%s gen_count", tag), 64'(gen_count), 64'(e.e_gen));
    check($sformatf("%s state", tag), 64'(state), 64'(e.e_st));
    check($sformatf("%s stable", tag), 64'(stable), 64'(e.e_stb));
    check($sformatf("%s extinct", tag), 64'(extinct), 64'(e.e_grid == '0));
    check($sformatf("%s halted", tag), 64'(halted), 64'(e.e_st == S_HL));
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; seed = '0; load = 0; run = 0; step = 0; rate = '0; gen_limit = '0;

    // Ignored in IDLE, then blinker load and held single step
    add(0,1,1, 0,0,0,1, 64'h0,0,S_ID,0);
    add(1,0,0, BLNK,0,0,1, BLNK,0,S_PS,0);
    add(0,0,1, 0,0,0,3, VERT,1,S_PS,0);
    add(0,0,0, 0,0,0,1, VERT,1,S_PS,0);
    // Rate divider: rate=3 commits every 4 cycles after entering RUN
    add(1,0,0, BLNK,3,0,1, BLNK,0,S_PS,0);
    add(0,1,0, 0,3,0,1, BLNK,0,S_RN,0);
    add(0,1,0, 0,3,0,3, BLNK,0,S_RN,0);
    add(0,1,0, 0,3,0,1, VERT,1,S_RN,0);
    add(0,1,0, 0,3,0,3, VERT,1,S_RN,0);
    add(0,1,0, 0,3,0,1, BLNK,2,S_RN,0);
    add(0,1,0, 0,3,0,3, BLNK,2,S_RN,0);
    add(0,1,0, 0,3,0,1, VERT,3,S_RN,0);
    add(0,1,0, 0,3,0,3, VERT,3,S_RN,0);
    add(0,1,0, 0,3,0,1, BLNK,4,S_RN,0);
    add(0,0,0, 0,3,0,1, BLNK,4,S_PS,0);
    add(0,0,0, 0,3,0,2, BLNK,4,S_PS,0);
    // Generation limit 5 at rate 0
    add(1,0,0, BLNK,0,5,1, BLNK,0,S_PS,0);
    add(0,1,0, 0,0,5,1, BLNK,0,S_RN,0);
    add(0,1,0, 0,0,5,1, VERT,1,S_RN,0);
    add(0,1,0, 0,0,5,1, BLNK,2,S_RN,0);
    add(0,1,0, 0,0,5,1, VERT,3,S_RN,0);
    add(0,1,0, 0,0,5,1, BLNK,4,S_RN,0);
    add(0,1,0, 0,0,5,1, VERT,5,S_HL,0);
    add(0,1,0, 0,0,5,2, VERT,5,S_HL,0);
    add(0,0,1, 0,0,5,1, VERT,5,S_HL,0);
    add(0,0,0, 0,0,5,1, VERT,5,S_HL,0);
    // Limit lowered below gen_count never halts
    add(1,0,0, BLNK,0,0,1, BLNK,0,S_PS,0);
    add(0,1,0, 0,0,0,1, BLNK,0,S_RN,0);
    add(0,1,0, 0,0,0,1, VERT,1,S_RN,0);
    add(0,1,0, 0,0,0,1, BLNK,2,S_RN,0);
    add(0,1,0, 0,0,0,1, VERT,3,S_RN,0);
    add(0,1,0, 0,0,2,1, BLNK,4,S_RN,0);
    add(0,1,0, 0,0,2,1, VERT,5,S_RN,0);
    // Rate lowered mid-count takes effect at the next compare
    add(1,0,0, BLNK,3,0,1, BLNK,0,S_PS,0);
    add(0,1,0, 0,3,0,1, BLNK,0,S_RN,0);
    add(0,1,0, 0,3,0,1, BLNK,0,S_RN,0);
    add(0,1,0, 0,1,0,1, VERT,1,S_RN,0);
    add(0,1,0, 0,1,0,1, VERT,1,S_RN,0);
    add(0,1,0, 0,1,0,1, BLNK,2,S_RN,0);
    // Still life: load wins over run, first commit halts with stable
    add(1,1,0, BLK,0,0,1, BLK,0,S_PS,0);
    add(0,1,0, 0,0,0,1, BLK,0,S_RN,0);
    add(0,1,0, 0,0,0,1, BLK,1,S_HL,1);
    add(0,1,1, 0,0,0,2, BLK,1,S_HL,1);
    // Extinction, then load out of HALT
    add(1,0,0, 64'h1,0,0,1, 64'h1,0,S_PS,0);
    add(0,0,1, 0,0,0,1, 64'h0,1,S_HL,0);
    add(0,0,0, 0,0,0,1, 64'h0,1,S_HL,0);
    add(1,0,0, BLNK,0,0,1, BLNK,0,S_PS,0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    e.e_grid = '0; e.e_gen = '0; e.e_st = S_ID; e.e_stb = 1'b0; e.idx = -1;
    check_outputs("reset", e);
    reset = 1'b0;

    foreach (vt[i]) begin
      for (int r = 0; r < vt[i].rep; r++) begin
        @(negedge clk);
        load = vt[i].ld; run = vt[i].rn; step = vt[i].st; seed = vt[i].sd;
        rate = vt[i].rt; gen_limit = vt[i].lim;
        e.e_grid = vt[i].e_grid; e.e_gen = vt[i].e_gen; e.e_st = vt[i].e_st;
        e.e_stb = vt[i].e_stb; e.idx = i;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: empty queue at vector %0d", i);
        end else begin
          e = sb.pop_front();
          check_outputs($sformatf("vec%0d", e.idx), e);
        end
      end
    end

    // Asynchronous reset asserted mid-RUN, between clock edges
    @(negedge clk);
    load = 1; seed = BLNK; run = 0; step = 0; rate = '0; gen_limit = '0;
    @(negedge clk);
    load = 0; run = 1;
    repeat (4) @(negedge clk);
    check("prerst gen_count", 64'(gen_count), 64'd3);
    check("prerst grid", grid, VERT);
    #2 reset = 1'b1;
    #1;
    e.e_grid = '0; e.e_gen = '0; e.e_st = S_ID; e.e_stb = 1'b0; e.idx = -2;
    check_outputs("async_rst", e);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst idle", 64'(state), 64'(S_ID));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
